// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory APB master: RV32I load/store
// funct3 encodings and the bus-stage state type.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_ERR
   } dmem_state_e;

endpackage

// File: rtl/dmem_apb_master_if.sv
// Datapath request/response handshake plus APB data-memory bus, bundled
// for the load/store stage. master = the bus stage, slave = its environment.
interface dmem_apb_master_if #(
   parameter int unsigned ADDR_W = 32
);

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;
   logic [ADDR_W-1:0] paddr;
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [31:0]       pwdata;
   logic [3:0]        pstrb;
   logic [31:0]       prdata;
   logic              pready;
   logic              pslverr;

   modport master (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  prdata, pready, pslverr,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output paddr, psel, penable, pwrite, pwdata, pstrb
   );

   modport slave (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      output prdata, pready, pslverr,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  paddr, psel, penable, pwrite, pwdata, pstrb
   );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the load/store stage: store strobes and replicated
// write data, access legality, and load-data extraction with extension.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] prdata,
   output logic [3:0]  pstrb,
   output logic [31:0] pwdata,
   output logic        illegal,
   output logic [31:0] rdata
);

   logic [31:0] lane;

   // Decode access size per funct3 into strobes, write lanes, legality and load extension.
   always_comb begin
      pstrb   = '0;
      pwdata  = '0;
      illegal = 1'b0;
      rdata   = '0;
      lane    = prdata >> {addr_lo, 3'b000};
      case (funct3)
         F3_B: begin
            pstrb  = 4'b0001 << addr_lo;
            pwdata = {4{wdata[7:0]}};
            rdata  = {{24{lane[7]}}, lane[7:0]};
         end
         F3_H: begin
            pstrb   = 4'b0011 << addr_lo;
            pwdata  = {2{wdata[15:0]}};
            illegal = addr_lo[0];
            rdata   = {{16{lane[15]}}, lane[15:0]};
         end
         F3_W: begin
            pstrb   = 4'hF;
            pwdata  = wdata;
            illegal = (addr_lo != 2'b00);
            rdata   = lane;
         end
         F3_BU: begin
            illegal = we;
            rdata   = {24'h0, lane[7:0]};
         end
         F3_HU: begin
            illegal = we | addr_lo[0];
            rdata   = {16'h0, lane[15:0]};
         end
         default: illegal = 1'b1;
      endcase
      if (!we) begin
         pstrb = '0;
      end
   end

endmodule

// File: rtl/dmem_apb_master.sv
// Load/store bus stage: accepts one datapath request, runs a single APB
// transfer (or rejects it locally), and returns an aligned, extended result.
module dmem_apb_master
   import dmem_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned ADDR_W  = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   dmem_apb_master_if.master      bus
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT);

   dmem_state_e       state_q, state_d;
   logic              we_q, we_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [1:0]        addr_lo_q, addr_lo_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [31:0]       pwdata_q, pwdata_d;
   logic [3:0]        pstrb_q, pstrb_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic [31:0]       rsp_rdata_q, rsp_rdata_d;

   logic              idle;
   logic              la_we;
   logic [2:0]        la_funct3;
   logic [1:0]        la_addr_lo;
   logic [3:0]        la_pstrb;
   logic [31:0]       la_pwdata;
   logic              la_illegal;
   logic [31:0]       la_rdata;

   assign idle = (state_q == S_IDLE);

   // One lane aligner serves both directions: live request fields while idle
   // (store lanes, legality), latched fields afterwards (load extraction).
   assign la_we      = idle ? bus.req_we         : we_q;
   assign la_funct3  = idle ? bus.req_funct3     : funct3_q;
   assign la_addr_lo = idle ? bus.req_addr[1:0]  : addr_lo_q;

   dmem_lane_align u_lane_align (
      .we      (la_we),
      .funct3  (la_funct3),
      .addr_lo (la_addr_lo),
      .wdata   (bus.req_wdata),
      .prdata  (bus.prdata),
      .pstrb   (la_pstrb),
      .pwdata  (la_pwdata),
      .illegal (la_illegal),
      .rdata   (la_rdata)
   );

   // Next-state and registered-output logic for the IDLE/SETUP/ACCESS/ERR sequence.
   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      funct3_d    = funct3_q;
      addr_lo_d   = addr_lo_q;
      cnt_d       = cnt_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      pstrb_d     = pstrb_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (bus.req_valid) begin
               we_d      = bus.req_we;
               funct3_d  = bus.req_funct3;
               addr_lo_d = bus.req_addr[1:0];
               if (la_illegal) begin
                  state_d = S_ERR;
               end else begin
                  state_d  = S_SETUP;
                  psel_d   = 1'b1;
                  pwrite_d = bus.req_we;
                  paddr_d  = {bus.req_addr[ADDR_W-1:2], 2'b00};
                  pwdata_d = la_pwdata;
                  pstrb_d  = la_pstrb;
               end
            end
         end
         S_ERR: begin
            state_d     = S_IDLE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
         end
         S_SETUP: begin
            state_d   = S_ACCESS;
            penable_d = 1'b1;
         end
         S_ACCESS: begin
            if (bus.pready) begin
               state_d     = S_IDLE;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = bus.pslverr;
               rsp_rdata_d = (!we_q && !bus.pslverr) ? la_rdata : '0;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d     = S_IDLE;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; reset drops the bus immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         we_q        <= 1'b0;
         funct3_q    <= '0;
         addr_lo_q   <= '0;
         cnt_q       <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pstrb_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         funct3_q    <= funct3_d;
         addr_lo_q   <= addr_lo_d;
         cnt_q       <= cnt_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         pstrb_q     <= pstrb_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign bus.req_ready = idle;
   assign bus.psel      = psel_q;
   assign bus.penable   = penable_q;
   assign bus.pwrite    = pwrite_q;
   assign bus.paddr     = paddr_q;
   assign bus.pwdata    = pwdata_q;
   assign bus.pstrb     = pstrb_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_apb_master.sv
// Self-checking bench for dmem_apb_master: directed scenarios plus random
// transactions against a byte-level reference model of RV32I load/store.
module tb_dmem_apb_master;
   import dmem_pkg::*;

   localparam int TMO = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   dmem_apb_master_if #(.ADDR_W(32)) bus ();

   dmem_apb_master #(.TIMEOUT(TMO), .ADDR_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference: access size from funct3, strobes/lanes/extension by byte arithmetic.
   function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] prdata,
                                 output bit illegal, output logic [3:0] strb,
                                 output logic [31:0] pw, output logic [31:0] rd);
      int size;
      int off;
      logic [31:0] mask;
      off  = int'(addr % 4);
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
      illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]) ||
                (size > 0 && (off % size) != 0);
      strb = '0;
      pw   = '0;
      rd   = '0;
      if (size > 0) begin
         if (we && !illegal) strb = 4'(((1 << size) - 1) << off);
         for (int i = 0; i < 4; i++) pw[8*i +: 8] = wdata[8*(i % size) +: 8];
         mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 1);
         rd = (prdata >> (8 * off)) & mask;
         if (!f3[2] && size < 4 && rd[8*size-1]) rd = rd | ~mask;
      end
   endfunction

   // One request from IDLE through response; called with clk low. waits>=TMO means never ready.
   task automatic do_txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] prdata,
                         input int waits, input bit slverr, input bit gap);
      bit          ill, tmo, exp_err;
      logic [3:0]  strb;
      logic [31:0] pw, rd, exp_rd;
      int          n;
      model(we, f3, addr, wdata, prdata, ill, strb, pw, rd);
      tmo     = (waits >= TMO);
      n       = tmo ? TMO : waits + 1;
      exp_err = ill || tmo || slverr;
      exp_rd  = (!we && !exp_err) ? rd : 32'h0;

      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      checks++;
      if (bus.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL req_ready_idle: got %b want 1", bus.req_ready);
      end
      @(posedge clk);
      #1;
      bus.req_valid  = 1'($urandom);
      bus.req_we     = 1'($urandom);
      bus.req_funct3 = 3'($urandom);
      bus.req_addr   = $urandom;
      bus.req_wdata  = $urandom;
      @(negedge clk);
      if (ill) begin
         checks++;
         if ({bus.req_ready, bus.psel, bus.penable, bus.rsp_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL err_state: ready/psel/penable/rsp_valid got %b want 0000",
                     {bus.req_ready, bus.psel, bus.penable, bus.rsp_valid});
         end
         bus.req_valid = 1'b0;
         @(posedge clk);
      end else begin
         checks++;
         if ({bus.psel, bus.penable, bus.pwrite, bus.req_ready, bus.rsp_valid} !== {2'b10, we, 2'b00}) begin
            errors++;
            $display("FAIL setup_ctrl: psel/penable/pwrite/ready/rsp_valid got %b want %b",
                     {bus.psel, bus.penable, bus.pwrite, bus.req_ready, bus.rsp_valid}, {2'b10, we, 2'b00});
         end
         checks++;
         if ({bus.paddr, bus.pstrb} !== {addr[31:2], 2'b00, strb}) begin
            errors++;
            $display("FAIL setup_addr_strb: paddr=%h pstrb=%b want paddr=%h pstrb=%b",
                     bus.paddr, bus.pstrb, {addr[31:2], 2'b00}, strb);
         end
         if (we) begin
            checks++;
            if (bus.pwdata !== pw) begin
               errors++;
               $display("FAIL setup_pwdata: got %h want %h", bus.pwdata, pw);
            end
         end
         @(posedge clk);
         for (int c = 0; c < n; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.psel, bus.penable, bus.rsp_valid, bus.req_ready, bus.pwrite, bus.paddr, bus.pstrb} !==
                {4'b1100, we, addr[31:2], 2'b00, strb}) begin
               errors++;
               $display("FAIL access_cycle%0d: psel/pen/rspv/rdy=%b paddr=%h pstrb=%b want 1100 %h %b",
                        c, {bus.psel, bus.penable, bus.rsp_valid, bus.req_ready}, bus.paddr, bus.pstrb,
                        {addr[31:2], 2'b00}, strb);
            end
            bus.pready    = (c == waits);
            bus.prdata    = (c == waits) ? prdata : $urandom;
            bus.pslverr   = (c == waits) ? slverr : 1'($urandom);
            bus.req_valid = (c == n - 1) ? 1'b0 : 1'($urandom);
            @(posedge clk);
         end
         #1;
         bus.pready  = 1'b0;
         bus.pslverr = 1'b0;
      end
      @(negedge clk);
      checks++;
      if ({bus.rsp_valid, bus.rsp_err, bus.psel, bus.penable, bus.req_ready} !== {1'b1, exp_err, 3'b001}) begin
         errors++;
         $display("FAIL rsp_ctrl: valid/err/psel/pen/rdy got %b want %b",
                  {bus.rsp_valid, bus.rsp_err, bus.psel, bus.penable, bus.req_ready}, {1'b1, exp_err, 3'b001});
      end
      checks++;
      if (bus.rsp_rdata !== exp_rd) begin
         errors++;
         $display("FAIL rsp_rdata: got %h want %h (f3=%b addr=%h prdata=%h)", bus.rsp_rdata, exp_rd, f3, addr, prdata);
      end
      if (gap) begin
         @(negedge clk);
         checks++;
         if ({bus.rsp_valid, bus.psel} !== 2'b00) begin
            errors++;
            $display("FAIL rsp_pulse_width: rsp_valid/psel got %b want 00", {bus.rsp_valid, bus.psel});
         end
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err, bus.req_ready} !== 6'b000001) begin
         errors++;
         $display("FAIL reset_ctrl: got %b want 000001",
                  {bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err, bus.req_ready});
      end
      checks++;
      if ({bus.paddr, bus.pwdata, bus.pstrb, bus.rsp_rdata} !== '0) begin
         errors++;
         $display("FAIL reset_data: paddr=%h pwdata=%h pstrb=%b rdata=%h want all 0",
                  bus.paddr, bus.pwdata, bus.pstrb, bus.rsp_rdata);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_store_word();
      do_txn(1'b1, F3_W, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, 1'b0, 1'b1);
   endtask

   task automatic test_loads();
      do_txn(1'b0, F3_B,  32'h13, 32'h0, 32'h8011_2233, 0, 1'b0, 1'b1);
      do_txn(1'b0, F3_BU, 32'h13, 32'h0, 32'h8011_2233, 0, 1'b0, 1'b1);
      do_txn(1'b0, F3_HU, 32'h12, 32'h0, 32'h8011_2233, 0, 1'b0, 1'b1);
      do_txn(1'b0, F3_H,  32'h12, 32'h0, 32'h8011_2233, 0, 1'b0, 1'b1);
      do_txn(1'b0, F3_W,  32'h14, 32'h0, 32'hCAFE_F00D, 1, 1'b0, 1'b1);
   endtask

   task automatic test_store_lanes_and_illegal();
      do_txn(1'b1, F3_H,   32'h06, 32'h0000_ABCD, 32'h0, 0, 1'b0, 1'b1);
      do_txn(1'b1, F3_B,   32'h21, 32'h1234_5678, 32'h0, 0, 1'b0, 1'b1);
      do_txn(1'b0, F3_W,   32'h05, 32'h0, 32'h0, 0, 1'b0, 1'b1);
      do_txn(1'b0, F3_HU,  32'h07, 32'h0, 32'h0, 0, 1'b0, 1'b1);
      do_txn(1'b1, F3_BU,  32'h08, 32'h0, 32'h0, 0, 1'b0, 1'b1);
      do_txn(1'b0, 3'b011, 32'h08, 32'h0, 32'h0, 0, 1'b0, 1'b1);
   endtask

   task automatic test_wait_slverr();
      do_txn(1'b0, F3_W, 32'h40, 32'h0, 32'h1111_2222, 3, 1'b1, 1'b1);
      do_txn(1'b0, F3_H, 32'h42, 32'h0, 32'h9000_0000, 2, 1'b0, 1'b1);
      do_txn(1'b1, F3_W, 32'h44, 32'h5555_AAAA, 32'h0, 1, 1'b1, 1'b1);
   endtask

   task automatic test_timeout();
      do_txn(1'b0, F3_W, 32'h80, 32'h0, 32'h0, TMO + 4, 1'b0, 1'b1);
      do_txn(1'b1, F3_W, 32'h84, 32'h0BAD_CAFE, 32'h0, TMO - 1, 1'b0, 1'b1);
   endtask

   task automatic test_back_to_back();
      do_txn(1'b1, F3_W, 32'h100, 32'h0102_0304, 32'h0, 0, 1'b0, 1'b0);
      do_txn(1'b0, F3_B, 32'h101, 32'h0, 32'h0000_7F00, 0, 1'b0, 1'b0);
      do_txn(1'b0, F3_W, 32'h102, 32'h0, 32'h0, 0, 1'b0, 1'b0);
      do_txn(1'b0, F3_HU, 32'h102, 32'h0, 32'hFFEE_0000, 1, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid();
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b0;
      bus.req_funct3 = F3_W;
      bus.req_addr   = 32'h200;
      bus.pready     = 1'b0;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.psel, bus.penable} !== 2'b11) begin
         errors++;
         $display("FAIL reset_mid_pre: psel/penable got %b want 11", {bus.psel, bus.penable});
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.psel, bus.penable, bus.rsp_valid, bus.req_ready, bus.paddr} !== {4'b0001, 32'h0}) begin
         errors++;
         $display("FAIL reset_mid_async: psel/pen/rspv/rdy got %b paddr=%h want 0001 0",
                  {bus.psel, bus.penable, bus.rsp_valid, bus.req_ready}, bus.paddr);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_no_rsp: rsp_valid got %b want 0", bus.rsp_valid);
      end
      rst_n = 1'b1;
      @(negedge clk);
      do_txn(1'b0, F3_B, 32'h203, 32'h0, 32'h7F00_0000, 0, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      bit          we;
      logic [2:0]  f3;
      logic [31:0] addr;
      int          waits;
      for (int i = 0; i < 60; i++) begin
         we    = 1'($urandom);
         f3    = 3'($urandom);
         addr  = $urandom;
         waits = ($urandom_range(0, 7) == 7) ? TMO + int'($urandom_range(0, 3)) : int'($urandom_range(0, 3));
         do_txn(we, f3, addr, $urandom, $urandom, waits, 1'($urandom_range(0, 3) == 0), 1'($urandom));
      end
   endtask

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = '0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.prdata     = '0;
      bus.pready     = 1'b0;
      bus.pslverr    = 1'b0;
      test_reset();
      test_store_word();
      test_loads();
      test_store_lanes_and_illegal();
      test_wait_slverr();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
